bitty_prog_loader: RTL and testbench

Writer-side counterpart to the Bitty instruction memory, which the core only reads. It receives a byte stream from Tiny Tapeout pins, assembles 16-bit instructions MSB-first, and writes them into instruction memory from address 0. The Bitty run sequencer is held off with cpu_hold until the transfer completes. A trailing XOR checksum validates the image.

---
 rtl/bitty_loader_pkg.sv | 16 +
 rtl/bitty_strobe_sync.sv | 26 ++
 rtl/bitty_prog_loader.sv | 92 +++++++++
 tb/tb_bitty_prog_loader.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/bitty_loader_pkg.sv
// bitty_loader_pkg: shared types and defaults for the Bitty program loader.
package bitty_loader_pkg;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;
  localparam int LEN_ZERO_MEANS = 256;
  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_LEN,
    S_GET_HI,
    S_GET_LO,
    S_WRITE,
    S_GET_CK,
    S_DONE,
    S_ERR
  } state_e;
endpackage

// File: rtl/bitty_strobe_sync.sv
// bitty_strobe_sync: synchronizes an asynchronous pin strobe and emits one take pulse per rising edge.
module bitty_strobe_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic stb_i,
  output logic take_o
);
  logic [STAGES-1:0] sync_q;
  logic last_q;
  logic take_q;
  // take is registered so it lands STAGES+1 edges after the first sampled high
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      last_q <= 1'b0;
      take_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], stb_i};
      last_q <= sync_q[STAGES-1];
      take_q <= sync_q[STAGES-1] & ~last_q;
    end
  end
  assign take_o = take_q;
endmodule

// File: rtl/bitty_prog_loader.sv
// bitty_prog_loader: loads a length-prefixed, XOR-checksummed byte stream into Bitty instruction memory.
module bitty_prog_loader
  import bitty_loader_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_stb,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              load_done,
  output logic              cksum_err
);
  state_e state_q, state_d;
  logic take;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [7:0] cksum_q;
  logic [7:0] hi_q;
  logic [8:0] rem_q;
  bitty_strobe_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .stb_i (byte_stb),
    .take_o(take)
  );
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    if (start) state_d = S_GET_LEN;
    else begin
      case (state_q)
        S_GET_LEN: if (take) state_d = S_GET_HI;
        S_GET_HI:  if (take) state_d = S_GET_LO;
        S_GET_LO:  if (take) state_d = S_WRITE;
        S_WRITE:   state_d = (rem_q == 9'd1) ? S_GET_CK : S_GET_HI;
        S_GET_CK:  if (take) state_d = (byte_in == cksum_q) ? S_DONE : S_ERR;
        default:   state_d = state_q;
      endcase
    end
  end
  // start wins over a coincident take, so the datapath ignores take on that edge
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      cksum_q <= '0;
      hi_q    <= '0;
      rem_q   <= '0;
    end else if (start) begin
      addr_q  <= '0;
      cksum_q <= '0;
    end else begin
      if (take && state_q == S_GET_LEN) begin
        rem_q   <= (byte_in == 8'd0) ? 9'(LEN_ZERO_MEANS) : {1'b0, byte_in};
        cksum_q <= cksum_q ^ byte_in;
      end
      if (take && state_q == S_GET_HI) begin
        hi_q    <= byte_in;
        cksum_q <= cksum_q ^ byte_in;
      end
      if (take && state_q == S_GET_LO) begin
        wdata_q <= DATA_W'({hi_q, byte_in});
        cksum_q <= cksum_q ^ byte_in;
      end
      if (state_q == S_WRITE) begin
        addr_q <= addr_q + ADDR_W'(1);
        rem_q  <= rem_q - 9'd1;
      end
    end
  end
  always_comb begin
    mem_we    = state_q == S_WRITE;
    busy      = state_q inside {S_GET_LEN, S_GET_HI, S_GET_LO, S_WRITE, S_GET_CK};
    cpu_hold  = busy || state_q == S_ERR;
    load_done = state_q == S_DONE;
    cksum_err = state_q == S_ERR;
  end
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
endmodule

// File: tb/tb_bitty_prog_loader.sv
// tb_bitty_prog_loader: directed self-checking bench for the Bitty program loader.
module tb_bitty_prog_loader;
  logic clk, reset, start, byte_stb, mem_we, cpu_hold, busy, load_done, cksum_err;
  logic [7:0] byte_in;
  logic [7:0] mem_addr;
  logic [15:0] mem_wdata;
  int n_checks = 0;
  int n_errors = 0;
  int wr_n = 0;
  logic [7:0] wr_addr [512];
  logic [15:0] wr_data [512];
  bitty_prog_loader dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .byte_in  (byte_in),
    .byte_stb (byte_stb),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .load_done(load_done),
    .cksum_err(cksum_err)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (mem_we && wr_n < 512) begin
      wr_addr[wr_n] = mem_addr;
      wr_data[wr_n] = mem_wdata;
      wr_n = wr_n + 1;
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send_byte(input logic [7:0] b);
    byte_in = b;
    byte_stb = 1'b1;
    repeat (4) @(posedge clk);
    #1 byte_stb = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic check_status(input string tag, input logic d, input logic e, input logic h, input logic b);
    @(negedge clk);
    check({tag, ".load_done"}, load_done, d);
    check({tag, ".cksum_err"}, cksum_err, e);
    check({tag, ".cpu_hold"}, cpu_hold, h);
    check({tag, ".busy"}, busy, b);
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [7:0] ck;
    int bad, nwe, at;
    reset = 1'b1;
    start = 1'b0;
    byte_stb = 1'b0;
    byte_in = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.mem_we", mem_we, 0);
    check("rst.mem_addr", mem_addr, 0);
    check("rst.mem_wdata", mem_wdata, 0);
    check("rst.cpu_hold", cpu_hold, 0);
    check("rst.busy", busy, 0);
    check("rst.load_done", load_done, 0);
    check("rst.cksum_err", cksum_err, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    // happy path
    pulse_start();
    wr_n = 0;
    check_status("start", 0, 0, 1, 1);
    send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
    send_byte(8'hAB); send_byte(8'hCD); send_byte(8'h42);
    check("ok.nwr", wr_n, 2);
    check("ok.a0", wr_addr[0], 8'h00);
    check("ok.d0", wr_data[0], 16'h1234);
    check("ok.a1", wr_addr[1], 8'h01);
    check("ok.d1", wr_data[1], 16'hABCD);
    check("ok.mem_addr", mem_addr, 8'h02);
    check("ok.mem_we", mem_we, 0);
    check_status("ok", 1, 0, 0, 0);
    // bad checksum
    pulse_start();
    wr_n = 0;
    send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
    send_byte(8'hAB); send_byte(8'hCD); send_byte(8'h43);
    check("bad.nwr", wr_n, 2);
    check("bad.d1", wr_data[1], 16'hABCD);
    check_status("bad", 0, 1, 1, 0);
    repeat (10) @(posedge clk);
    #1;
    check_status("bad.later", 0, 1, 1, 0);
    // length 0 means 256 words
    pulse_start();
    wr_n = 0;
    ck = 8'h00;
    send_byte(8'h00);
    for (int i = 0; i < 256; i++) begin
      send_byte(8'(i));
      send_byte(~8'(i));
      ck = ck ^ 8'(i) ^ ~8'(i);
    end
    send_byte(ck);
    check("len0.nwr", wr_n, 256);
    bad = 0;
    for (int i = 0; i < 256; i++)
      if (wr_addr[i] !== 8'(i) || wr_data[i] !== {8'(i), ~8'(i)}) bad++;
    check("len0.bad_words", bad, 0);
    check("len0.mem_addr", mem_addr, 8'h00);
    check_status("len0", 1, 0, 0, 0);
    // reset after the first write
    pulse_start();
    wr_n = 0;
    send_byte(8'h02); send_byte(8'h11); send_byte(8'h22);
    check("rml.nwr", wr_n, 1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rml.mem_we", mem_we, 0);
    check("rml.mem_addr", mem_addr, 0);
    check("rml.cpu_hold", cpu_hold, 0);
    check("rml.busy", busy, 0);
    @(posedge clk);
    #1;
    pulse_start();
    wr_n = 0;
    send_byte(8'h01); send_byte(8'h55); send_byte(8'h66); send_byte(8'h32);
    check("rml2.nwr", wr_n, 1);
    check("rml2.a0", wr_addr[0], 8'h00);
    check("rml2.d0", wr_data[0], 16'h5566);
    check_status("rml2", 1, 0, 0, 0);
    // start coinciding with the take of a GET_LO byte
    pulse_start();
    wr_n = 0;
    send_byte(8'h02); send_byte(8'h11); send_byte(8'h22); send_byte(8'h77);
    byte_in = 8'h88;
    byte_stb = 1'b1;
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 byte_stb = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("coin.nwr", wr_n, 1);
    check("coin.mem_addr", mem_addr, 8'h00);
    check_status("coin", 0, 0, 1, 1);
    send_byte(8'h01); send_byte(8'h9A); send_byte(8'hBC); send_byte(8'h27);
    check("coin2.nwr", wr_n, 2);
    check("coin2.a", wr_addr[1], 8'h00);
    check("coin2.d", wr_data[1], 16'h9ABC);
    check_status("coin2", 1, 0, 0, 0);
    // long strobe and sub-cycle glitch
    pulse_start();
    wr_n = 0;
    send_byte(8'h03); send_byte(8'h11);
    byte_in = 8'h22;
    byte_stb = 1'b1;
    nwe = 0;
    at = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (mem_we) begin
        nwe++;
        if (at < 0) at = i;
      end
    end
    check("long.nwe", nwe, 1);
    check("long.latency", at, 4);
    @(posedge clk);
    #1 byte_stb = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    send_byte(8'h33); send_byte(8'h44);
    @(posedge clk);
    #8 byte_in = 8'h55;
    byte_stb = 1'b1;
    #4 byte_stb = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    send_byte(8'h66); send_byte(8'h74);
    check("strb.nwr", wr_n, 3);
    check("strb.d0", wr_data[0], 16'h1122);
    check("strb.d1", wr_data[1], 16'h3344);
    check("strb.a2", wr_addr[2], 8'h02);
    check("strb.d2", wr_data[2], 16'h5566);
    check_status("strb", 1, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
